// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC channel scheduler and its arbiter.
// The command word is {channel, config, sample}, MSB first.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int WORD_W = 16;
  localparam int SAMPLE_LSB = 0;
  localparam logic [2:0] DEFAULT_CFG = 3'b011;

  // Config field starts right above the sample; the channel field sits above it.
  function automatic int cfg_lsb(input int data_w);
    return SAMPLE_LSB + data_w;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin select: the first set request found searching
// last+1, last+2, ... (mod N). N must be a power of two so the index wraps.
module rr_arb #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    cand   = '0;
    valid  = |req;
    for (int k = N; k >= 1; k--) begin
      cand = last + IW'(k);
      if (req[cand]) begin
        idx         = cand;
        onehot      = '0;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_ch_sched.sv
// Round-robin scheduler sharing one SPI DAC writer between N_CH producers;
// builds the command word, spaces frames by GAP_CYC and times out hung frames.
module dac_ch_sched
  import dac_sched_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DATA_W = 12,
  localparam int CH_W = $clog2(N_CH),
  localparam int CFG_W = WORD_W - DATA_W - CH_W,
  parameter logic [CFG_W-1:0] CFG = CFG_W'(DEFAULT_CFG),
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          req_i,
  input  logic [N_CH*DATA_W-1:0]   data_i,
  output logic [N_CH-1:0]          gnt_o,
  output logic                     spi_start_o,
  output logic [WORD_W-1:0]        spi_data_o,
  input  logic                     spi_end_i,
  output logic                     busy_o,
  output logic [CH_W-1:0]          ch_o,
  output logic                     err_o,
  output state_t                   state_o
);

  // Writer handshake: spi_start_o pulses once per frame with spi_data_o already
  // stable; the writer answers with a single spi_end_i pulse, honoured only in WAIT.

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam state_t END_NEXT = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;

  state_t            state, state_nx;
  logic [CH_W-1:0]   last;
  logic [N_CH-1:0]   gnt_vec;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              take, timeout;

  logic [N_CH-1:0]   arb_onehot;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_valid;
  logic [DATA_W-1:0] sel_data;

  rr_arb #(.N(N_CH)) u_arb (
    .req    (req_i),
    .last   (last),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  assign sel_data = data_i[arb_idx*DATA_W +: DATA_W];
  assign state_o  = state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    timeout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          take     = 1'b1;
          state_nx = ST_START;
        end
      end
      ST_START: state_nx = ST_WAIT;
      ST_WAIT: begin
        // A completion arriving on the last allowed cycle still counts as success.
        if (spi_end_i) begin
          state_nx = END_NEXT;
        end else if (to_cnt == TO_LAST) begin
          timeout  = 1'b1;
          state_nx = END_NEXT;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_o       <= '0;
      spi_start_o <= 1'b0;
      spi_data_o  <= '0;
      busy_o      <= 1'b0;
      ch_o        <= '0;
      err_o       <= 1'b0;
      last        <= CH_W'(N_CH - 1);
      gnt_vec     <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      spi_start_o <= (state == ST_START);
      gnt_o       <= (state == ST_START) ? gnt_vec : '0;
      busy_o      <= (state_nx != ST_IDLE);
      err_o       <= err_o | timeout;
      to_cnt      <= (state == ST_WAIT) ? to_cnt + TO_W'(1) : '0;
      gap_cnt     <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (take) begin
        ch_o       <= arb_idx;
        last       <= arb_idx;
        gnt_vec    <= arb_onehot;
        spi_data_o <= {arb_idx, CFG, sel_data};
      end
    end
  end

endmodule
